io_dev_arbiter: RTL and testbench

Shares the I/O unit's two 5-bit character channels among the physical peripherals. On the input side it arbitrates between the tape reader and the panel keyboard. On the output side it buffers characters from the I/O unit in a small FIFO and broadcasts each one to the printer and/or punch. It sits between the I/O electronic unit and the device handshake pins, and every channel on both sides uses the same four-phase rdy/ack protocol.

---
 rtl/io_dev_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_io_dev_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_dev_arbiter.sv
// Shares the I/O unit's 5-bit input and output channels between the tape reader and keyboard
// on the input side, and the printer and punch on the output side. All channels use four-phase rdy/ack.
module io_dev_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tape_rdy_from_dev,
    output logic                          tape_ack_to_dev,
    input  logic [4:0]                    tape_data_from_dev,
    input  logic                          kbd_rdy_from_dev,
    output logic                          kbd_ack_to_dev,
    input  logic [4:0]                    kbd_data_from_dev,
    input  logic                          tape_en_from_pnl,
    input  logic                          kbd_en_from_pnl,
    output logic                          input_rdy_to_io,
    input  logic                          input_ack_from_io,
    output logic [4:0]                    input_data_to_io,
    input  logic                          output_rdy_from_io,
    output logic                          output_ack_to_io,
    input  logic [4:0]                    output_data_from_io,
    output logic                          prn_rdy_to_dev,
    input  logic                          prn_ack_from_dev,
    output logic [4:0]                    prn_data_to_dev,
    output logic                          pun_rdy_to_dev,
    input  logic                          pun_ack_from_dev,
    output logic [4:0]                    pun_data_to_dev,
    input  logic                          prn_en_from_pnl,
    input  logic                          pun_en_from_pnl,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy_to_pnl
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {I_IDLE, I_DACK, I_RDY, I_WAIT} in_state_t;
    typedef enum logic       {A_IDLE, A_ACK}                 acc_state_t;
    typedef enum logic       {D_IDLE, D_SEND}                drn_state_t;

    // ------------------------------------------------------------------
    // Input side: round-robin between tape and keyboard
    // ------------------------------------------------------------------
    in_state_t  i_state;
    logic       gnt_kbd;
    logic       last_kbd;
    logic [4:0] char_q;
    logic       tape_req;
    logic       kbd_req;
    logic       pick_kbd;

    assign tape_req = tape_en_from_pnl & tape_rdy_from_dev;
    assign kbd_req  = kbd_en_from_pnl & kbd_rdy_from_dev;
    // On a tie the keyboard wins unless it was the one served last.
    assign pick_kbd = kbd_req & (~tape_req | ~last_kbd);

    assign input_data_to_io = char_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_state         <= I_IDLE;
            gnt_kbd         <= 1'b0;
            last_kbd        <= 1'b0;
            char_q          <= '0;
            tape_ack_to_dev <= 1'b0;
            kbd_ack_to_dev  <= 1'b0;
            input_rdy_to_io <= 1'b0;
        end else begin
            case (i_state)
                I_IDLE: begin
                    if (tape_req | kbd_req) begin
                        gnt_kbd         <= pick_kbd;
                        char_q          <= pick_kbd ? kbd_data_from_dev : tape_data_from_dev;
                        tape_ack_to_dev <= ~pick_kbd;
                        kbd_ack_to_dev  <= pick_kbd;
                        i_state         <= I_DACK;
                    end
                end
                I_DACK: begin
                    if (!(gnt_kbd ? kbd_rdy_from_dev : tape_rdy_from_dev)) begin
                        tape_ack_to_dev <= 1'b0;
                        kbd_ack_to_dev  <= 1'b0;
                        input_rdy_to_io <= 1'b1;
                        i_state         <= I_RDY;
                    end
                end
                I_RDY: begin
                    if (input_ack_from_io) begin
                        input_rdy_to_io <= 1'b0;
                        i_state         <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    if (!input_ack_from_io) begin
                        last_kbd <= gnt_kbd;
                        i_state  <= I_IDLE;
                    end
                end
                default: i_state <= I_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output side: accept into FIFO, drain to printer and/or punch
    // ------------------------------------------------------------------
    acc_state_t a_state;
    drn_state_t d_state;
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          sel_prn, sel_pun;
    logic          got_prn, got_pun;
    logic          done_prn, done_pun;
    logic          all_done;
    logic [4:0]    head;

    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rd_ptr];
    assign all_done   = (~sel_prn | done_prn) & (~sel_pun | done_pun);
    assign push       = (a_state == A_IDLE) & output_rdy_from_io & ~fifo_full;
    // A character with no enabled sink is discarded straight from D_IDLE.
    assign pop        = ((d_state == D_IDLE) & ~fifo_empty & ~prn_en_from_pnl & ~pun_en_from_pnl)
                      | ((d_state == D_SEND) & all_done);

    assign busy_to_pnl = (i_state != I_IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_state          <= A_IDLE;
            output_ack_to_io <= 1'b0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    if (push) begin
                        output_ack_to_io <= 1'b1;
                        a_state          <= A_ACK;
                    end
                end
                A_ACK: begin
                    if (!output_rdy_from_io) begin
                        output_ack_to_io <= 1'b0;
                        a_state          <= A_IDLE;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count alone, which keeps the array plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= output_data_from_io;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state         <= D_IDLE;
            sel_prn         <= 1'b0;
            sel_pun         <= 1'b0;
            got_prn         <= 1'b0;
            got_pun         <= 1'b0;
            done_prn        <= 1'b0;
            done_pun        <= 1'b0;
            prn_rdy_to_dev  <= 1'b0;
            pun_rdy_to_dev  <= 1'b0;
            prn_data_to_dev <= '0;
            pun_data_to_dev <= '0;
        end else begin
            case (d_state)
                D_IDLE: begin
                    if (!fifo_empty) begin
                        sel_prn  <= prn_en_from_pnl;
                        sel_pun  <= pun_en_from_pnl;
                        got_prn  <= 1'b0;
                        got_pun  <= 1'b0;
                        done_prn <= 1'b0;
                        done_pun <= 1'b0;
                        if (prn_en_from_pnl | pun_en_from_pnl) d_state <= D_SEND;
                    end
                end
                D_SEND: begin
                    if (all_done) begin
                        sel_prn  <= 1'b0;
                        sel_pun  <= 1'b0;
                        got_prn  <= 1'b0;
                        got_pun  <= 1'b0;
                        done_prn <= 1'b0;
                        done_pun <= 1'b0;
                        d_state  <= D_IDLE;
                    end else begin
                        // Each sink runs its own handshake; done only after its ack falls.
                        if (sel_prn && !done_prn) begin
                            if (!got_prn) begin
                                if (prn_ack_from_dev) begin
                                    prn_rdy_to_dev <= 1'b0;
                                    got_prn        <= 1'b1;
                                end else begin
                                    prn_rdy_to_dev  <= 1'b1;
                                    prn_data_to_dev <= head;
                                end
                            end else if (!prn_ack_from_dev) begin
                                done_prn <= 1'b1;
                            end
                        end
                        if (sel_pun && !done_pun) begin
                            if (!got_pun) begin
                                if (pun_ack_from_dev) begin
                                    pun_rdy_to_dev <= 1'b0;
                                    got_pun        <= 1'b1;
                                end else begin
                                    pun_rdy_to_dev  <= 1'b1;
                                    pun_data_to_dev <= head;
                                end
                            end else if (!pun_ack_from_dev) begin
                                done_pun <= 1'b1;
                            end
                        end
                    end
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_dev_arbiter.sv
// Scoreboard bench for io_dev_arbiter: reactive device/io models, monitors that compare
// each offered character against queued expectations, and directed scenario checks.
module tb_io_dev_arbiter;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       tape_rdy, kbd_rdy;
    logic [4:0] tape_data, kbd_data;
    logic       tape_ack_to_dev, kbd_ack_to_dev;
    logic       tape_en, kbd_en, prn_en, pun_en;
    logic       input_rdy_to_io, input_ack_from_io;
    logic [4:0] input_data_to_io;
    logic       output_rdy_from_io, output_ack_to_io;
    logic [4:0] output_data_from_io;
    logic       prn_rdy_to_dev, prn_ack, pun_rdy_to_dev, pun_ack;
    logic [4:0] prn_data_to_dev, pun_data_to_dev;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       busy_to_pnl;

    io_dev_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .tape_rdy_from_dev(tape_rdy), .tape_ack_to_dev(tape_ack_to_dev), .tape_data_from_dev(tape_data),
        .kbd_rdy_from_dev(kbd_rdy), .kbd_ack_to_dev(kbd_ack_to_dev), .kbd_data_from_dev(kbd_data),
        .tape_en_from_pnl(tape_en), .kbd_en_from_pnl(kbd_en),
        .input_rdy_to_io(input_rdy_to_io), .input_ack_from_io(input_ack_from_io),
        .input_data_to_io(input_data_to_io),
        .output_rdy_from_io(output_rdy_from_io), .output_ack_to_io(output_ack_to_io),
        .output_data_from_io(output_data_from_io),
        .prn_rdy_to_dev(prn_rdy_to_dev), .prn_ack_from_dev(prn_ack), .prn_data_to_dev(prn_data_to_dev),
        .pun_rdy_to_dev(pun_rdy_to_dev), .pun_ack_from_dev(pun_ack), .pun_data_to_dev(pun_data_to_dev),
        .prn_en_from_pnl(prn_en), .pun_en_from_pnl(pun_en),
        .fifo_count(fifo_count), .busy_to_pnl(busy_to_pnl)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [4:0] exp_in[$], exp_prn[$], exp_pun[$];
    logic [4:0] tape_q[$], kbd_q[$], io_q[$];
    bit  io_hold = 0, prn_hold = 0, pun_hold = 0;
    int  prn_delay = 1, pun_delay = 1;
    int  tape_ack_rises = 0, kbd_ack_rises = 0, out_ack_rises = 0;
    int  prn_rises = 0, pun_rises = 0;
    int  prn_rise_t[$], pun_fall_t[$];
    int  run_len = 0, max_run = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // ---------------- device / io models (react on negedge) ----------------
    initial begin
        tape_rdy = 0; tape_data = 0;
        forever begin
            @(negedge clk);
            if (tape_rdy && tape_ack_to_dev) tape_rdy = 0;
            else if (!tape_rdy && !tape_ack_to_dev && tape_q.size() > 0) begin
                tape_data = tape_q.pop_front();
                tape_rdy  = 1;
            end
        end
    end

    initial begin
        kbd_rdy = 0; kbd_data = 0;
        forever begin
            @(negedge clk);
            if (kbd_rdy && kbd_ack_to_dev) kbd_rdy = 0;
            else if (!kbd_rdy && !kbd_ack_to_dev && kbd_q.size() > 0) begin
                kbd_data = kbd_q.pop_front();
                kbd_rdy  = 1;
            end
        end
    end

    initial begin
        output_rdy_from_io = 0; output_data_from_io = 0;
        forever begin
            @(negedge clk);
            if (output_rdy_from_io && output_ack_to_io) output_rdy_from_io = 0;
            else if (!output_rdy_from_io && !output_ack_to_io && io_q.size() > 0) begin
                output_data_from_io = io_q.pop_front();
                output_rdy_from_io  = 1;
            end
        end
    end

    initial begin
        input_ack_from_io = 0;
        forever begin
            @(negedge clk);
            if (input_rdy_to_io && !input_ack_from_io && !io_hold) input_ack_from_io = 1;
            else if (!input_rdy_to_io && input_ack_from_io) input_ack_from_io = 0;
        end
    end

    initial begin
        prn_ack = 0;
        forever begin
            @(negedge clk);
            if (prn_rdy_to_dev && !prn_ack && !prn_hold) begin
                repeat (prn_delay - 1) @(negedge clk);
                prn_ack = 1;
            end else if (!prn_rdy_to_dev && prn_ack) prn_ack = 0;
        end
    end

    initial begin
        pun_ack = 0;
        forever begin
            @(negedge clk);
            if (pun_rdy_to_dev && !pun_ack && !pun_hold) begin
                repeat (pun_delay - 1) @(negedge clk);
                pun_ack = 1;
            end else if (!pun_rdy_to_dev && pun_ack) pun_ack = 0;
        end
    end

    // ---------------- monitor: pops scoreboard on each offered character ----------------
    logic p_in = 0, p_prn = 0, p_pun = 0, p_pun_ack = 0, p_tack = 0, p_kack = 0, p_oack = 0;

    initial forever begin
        @(negedge clk);
        if (input_rdy_to_io && !p_in) begin
            check("in_expected", 32'(exp_in.size() > 0), 32'd1);
            if (exp_in.size() > 0) check("in_data", 32'(input_data_to_io), 32'(exp_in.pop_front()));
        end
        if (prn_rdy_to_dev && !p_prn) begin
            prn_rises++;
            prn_rise_t.push_back(cyc);
            check("prn_expected", 32'(exp_prn.size() > 0), 32'd1);
            if (exp_prn.size() > 0) check("prn_data", 32'(prn_data_to_dev), 32'(exp_prn.pop_front()));
        end
        if (pun_rdy_to_dev && !p_pun) begin
            pun_rises++;
            check("pun_expected", 32'(exp_pun.size() > 0), 32'd1);
            if (exp_pun.size() > 0) check("pun_data", 32'(pun_data_to_dev), 32'(exp_pun.pop_front()));
        end
        if (!pun_ack && p_pun_ack) pun_fall_t.push_back(cyc);
        if (tape_ack_to_dev && !p_tack) tape_ack_rises++;
        if (kbd_ack_to_dev && !p_kack) kbd_ack_rises++;
        if (output_ack_to_io && !p_oack) out_ack_rises++;
        if (fifo_count != 0) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        p_in = input_rdy_to_io; p_prn = prn_rdy_to_dev; p_pun = pun_rdy_to_dev;
        p_pun_ack = pun_ack; p_tack = tape_ack_to_dev; p_kack = kbd_ack_to_dev;
        p_oack = output_ack_to_io;
    end

    task automatic wait_quiet(input string name, input int budget);
        int  n = 0;
        bit  quiet = 0;
        while (!quiet && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (tape_q.size() == 0) && (kbd_q.size() == 0) && (io_q.size() == 0)
                 && (exp_in.size() == 0) && (exp_prn.size() == 0) && (exp_pun.size() == 0)
                 && !tape_rdy && !kbd_rdy && !output_rdy_from_io && !input_ack_from_io
                 && !prn_ack && !pun_ack && !busy_to_pnl
                 && ({tape_ack_to_dev, kbd_ack_to_dev, input_rdy_to_io, output_ack_to_io,
                      prn_rdy_to_dev, pun_rdy_to_dev} == 6'b0);
        end
        check({name, "_completes"}, 32'(quiet), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int a0, p0, q0, t0, k0;
        bit ok;
        reset = 1;
        tape_en = 0; kbd_en = 0; prn_en = 0; pun_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lines", 32'({tape_ack_to_dev, kbd_ack_to_dev, input_rdy_to_io, output_ack_to_io,
                                prn_rdy_to_dev, pun_rdy_to_dev}), 32'd0);
        check("rst_in_data", 32'(input_data_to_io), 32'd0);
        check("rst_prn_data", 32'(prn_data_to_dev), 32'd0);
        check("rst_pun_data", 32'(pun_data_to_dev), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy_to_pnl), 32'd0);
        sync();
        reset = 0;

        // Tape only: one handshake, keyboard never acked
        sync();
        t0 = tape_ack_rises; k0 = kbd_ack_rises;
        tape_en = 1;
        tape_q.push_back(5'h13); exp_in.push_back(5'h13);
        wait_quiet("t1", 100);
        check("t1_tape_acks", 32'(tape_ack_rises - t0), 32'd1);
        check("t1_kbd_acks", 32'(kbd_ack_rises - k0), 32'd0);

        // Both requesting continuously: keyboard first, then strict alternation
        sync();
        kbd_en = 1;
        tape_q.push_back(5'h11); tape_q.push_back(5'h11);
        kbd_q.push_back(5'h05);  kbd_q.push_back(5'h05);
        exp_in.push_back(5'h05); exp_in.push_back(5'h11);
        exp_in.push_back(5'h05); exp_in.push_back(5'h11);
        wait_quiet("t2", 200);

        // Broadcast to printer and slower punch; pop waits for the punch
        sync();
        tape_en = 0; kbd_en = 0; prn_en = 1; pun_en = 1; pun_delay = 11;
        prn_rise_t.delete(); pun_fall_t.delete();
        io_q.push_back(5'h1F); io_q.push_back(5'h06);
        exp_prn.push_back(5'h1F); exp_prn.push_back(5'h06);
        exp_pun.push_back(5'h1F); exp_pun.push_back(5'h06);
        wait_quiet("t3", 300);
        check("t3_pop_after_punch", 32'((prn_rise_t.size() == 2) && (pun_fall_t.size() >= 1)
                                        && (prn_rise_t[1] > pun_fall_t[0])), 32'd1);
        pun_delay = 1;

        // Sinks stalled: FIFO fills to 4, fifth character waits for the first pop
        sync();
        prn_hold = 1; pun_hold = 1;
        a0 = out_ack_rises;
        for (int i = 1; i <= 5; i++) begin
            io_q.push_back(5'(i)); exp_prn.push_back(5'(i)); exp_pun.push_back(5'(i));
        end
        repeat (40) @(negedge clk);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        check("t4_acks_while_full", 32'(out_ack_rises - a0), 32'd4);
        check("t4_fifth_stalled", 32'({output_rdy_from_io, output_ack_to_io}), 32'b10);
        sync();
        prn_hold = 0; pun_hold = 0;
        wait_quiet("t4", 400);
        check("t4_acks_total", 32'(out_ack_rises - a0), 32'd5);

        // No sink enabled: each character acked and discarded the next cycle
        sync();
        prn_en = 0; pun_en = 0;
        max_run = 0;
        a0 = out_ack_rises; p0 = prn_rises; q0 = pun_rises;
        io_q.push_back(5'h0B); io_q.push_back(5'h0C); io_q.push_back(5'h0D);
        wait_quiet("t5", 200);
        check("t5_acks", 32'(out_ack_rises - a0), 32'd3);
        check("t5_cycles_held", 32'(max_run), 32'd1);
        check("t5_sink_rdy", 32'((prn_rises - p0) + (pun_rises - q0)), 32'd0);

        // Reset while input waits in I_RDY and the printer is mid-send
        sync();
        prn_en = 1; prn_hold = 1; io_hold = 1; tape_en = 1;
        tape_q.push_back(5'h09); exp_in.push_back(5'h09);
        io_q.push_back(5'h15);   exp_prn.push_back(5'h15);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = input_rdy_to_io && prn_rdy_to_dev && !output_rdy_from_io && !output_ack_to_io;
        end
        check("t6_setup", 32'(ok), 32'd1);
        sync();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_lines", 32'({tape_ack_to_dev, kbd_ack_to_dev, input_rdy_to_io, output_ack_to_io,
                                   prn_rdy_to_dev, pun_rdy_to_dev}), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_busy", 32'(busy_to_pnl), 32'd0);
        sync();
        reset = 0; io_hold = 0; prn_hold = 0; prn_en = 0;
        tape_q.push_back(5'h0A); exp_in.push_back(5'h0A);
        wait_quiet("t6", 200);

        check("end_queues_empty", 32'(exp_in.size() + exp_prn.size() + exp_pun.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
